// File: rtl/operand_fetch.sv
// +--------------------------------------------------------------------------+
// | operand_fetch: fetches two source operands from a registered-read        |
// | register file, forwards in-flight writebacks, and owns the write port.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module operand_fetch #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_src1,
  input  logic [ADDR_WIDTH-1:0] req_src2,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] rf_read_addr1,
  output logic [ADDR_WIDTH-1:0] rf_read_addr2,
  input  logic [DATA_WIDTH-1:0] rf_data1,
  input  logic [DATA_WIDTH-1:0] rf_data2,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  rf_write_enable
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    VALID   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src1_q, src1_d;
  logic [ADDR_WIDTH-1:0] src2_q, src2_d;
  logic                  fwd1_q, fwd1_d;
  logic                  fwd2_q, fwd2_d;
  logic [DATA_WIDTH-1:0] fwd_data1_q, fwd_data1_d;
  logic [DATA_WIDTH-1:0] fwd_data2_q, fwd_data2_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic                  wb_hit1;
  logic                  wb_hit2;

  // The write port is a straight pass-through; writeback is never stalled.
  assign rf_write_enable = wb_valid & rst_n;
  assign rf_write_addr   = wb_addr;
  assign rf_write_data   = wb_data;

  assign wb_hit1 = wb_valid && (wb_addr == src1_q);
  assign wb_hit2 = wb_valid && (wb_addr == src2_q);

  assign rf_read_addr1 = src1_q;
  assign rf_read_addr2 = src2_q;
  assign req_ready     = (state_q == IDLE);
  assign op_valid      = (state_q == VALID);
  assign op_a          = op_a_q;
  assign op_b          = op_b_q;

  always_comb begin
    state_d     = state_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    fwd1_d      = fwd1_q;
    fwd2_d      = fwd2_q;
    fwd_data1_d = fwd_data1_q;
    fwd_data2_d = fwd_data2_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          src1_d  = req_src1;
          src2_d  = req_src2;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The register file samples pre-write contents at this edge, so a
        // write landing now must be remembered for the capture stage.
        if (wb_hit1) begin
          fwd1_d      = 1'b1;
          fwd_data1_d = wb_data;
        end
        if (wb_hit2) begin
          fwd2_d      = 1'b1;
          fwd_data2_d = wb_data;
        end
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (wb_hit1)     op_a_d = wb_data;
        else if (fwd1_q) op_a_d = fwd_data1_q;
        else             op_a_d = rf_data1;
        if (wb_hit2)     op_b_d = wb_data;
        else if (fwd2_q) op_b_d = fwd_data2_q;
        else             op_b_d = rf_data2;
        state_d = VALID;
      end
      VALID: begin
        if (wb_hit1) op_a_d = wb_data;
        if (wb_hit2) op_b_d = wb_data;
        if (op_ready) begin
          fwd1_d  = 1'b0;
          fwd2_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src1_q      <= '0;
      src2_q      <= '0;
      fwd1_q      <= 1'b0;
      fwd2_q      <= 1'b0;
      fwd_data1_q <= '0;
      fwd_data2_q <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
    end else begin
      state_q     <= state_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      fwd1_q      <= fwd1_d;
      fwd2_q      <= fwd2_d;
      fwd_data1_q <= fwd_data1_d;
      fwd_data2_q <= fwd_data2_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// +--------------------------------------------------------------------------+
// | tb_operand_fetch: directed bench for operand_fetch with a registered-read|
// | register file model. Revision: 1.0                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_operand_fetch;
  localparam int DW = 18;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_src1, req_src2;
  logic          op_valid, op_ready;
  logic [DW-1:0] op_a, op_b;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] rf_read_addr1, rf_read_addr2;
  logic [DW-1:0] rf_data1, rf_data2;
  logic [AW-1:0] rf_write_addr;
  logic [DW-1:0] rf_write_data;
  logic          rf_write_enable;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [16];

  always #5 clk = ~clk;

  // Register file: write and registered read share the edge; reads see old data.
  always @(posedge clk) begin
    if (rf_write_enable) mem[rf_write_addr] <= rf_write_data;
    rf_data1 <= mem[rf_read_addr1];
    rf_data2 <= mem[rf_read_addr2];
  end

  operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic request(input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    req_valid = 1'b1;
    req_src1  = s1;
    req_src2  = s2;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_src1 = '0; req_src2 = '0;
    op_ready = 1'b0; wb_valid = 1'b1; wb_addr = 4'd1; wb_data = 18'h12345;
    #1;
    chk("reset_op_valid", {31'd0, op_valid}, 32'd0);
    chk("reset_op_a", {14'd0, op_a}, 32'd0);
    chk("reset_op_b", {14'd0, op_b}, 32'd0);
    chk("reset_addr1", {28'd0, rf_read_addr1}, 32'd0);
    chk("reset_we_gated", {31'd0, rf_write_enable}, 32'd0);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    wb_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // Preload through the pass-through write port.
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 18'h00011;
    #1;
    chk("wport_enable", {31'd0, rf_write_enable}, 32'd1);
    chk("wport_data", {14'd0, rf_write_data}, 32'h00011);
    tick();
    wb_valid = 1'b0;
    wr(4'd7, 18'h3FFFF);
    wr(4'd0, 18'h00000);
    wr(4'd5, 18'h00100);

    // Basic fetch
    op_ready = 1'b1;
    request(4'd3, 4'd7);
    chk("basic_issue_ready", {31'd0, req_ready}, 32'd0);
    chk("basic_addr1", {28'd0, rf_read_addr1}, 32'd3);
    chk("basic_addr2", {28'd0, rf_read_addr2}, 32'd7);
    chk("basic_issue_valid", {31'd0, op_valid}, 32'd0);
    tick();
    chk("basic_capture_valid", {31'd0, op_valid}, 32'd0);
    tick();
    chk("basic_valid", {31'd0, op_valid}, 32'd1);
    chk("basic_op_a", {14'd0, op_a}, 32'h00011);
    chk("basic_op_b", {14'd0, op_b}, 32'h3FFFF);
    tick();
    chk("basic_valid_drop", {31'd0, op_valid}, 32'd0);
    chk("basic_ready_back", {31'd0, req_ready}, 32'd1);

    // Forward from a write during ISSUE
    request(4'd5, 4'd0);
    wr(4'd5, 18'h00222);
    tick();
    chk("fwd_issue_valid", {31'd0, op_valid}, 32'd1);
    chk("fwd_issue_op_a", {14'd0, op_a}, 32'h00222);
    chk("fwd_issue_op_b", {14'd0, op_b}, 32'h00000);
    tick();

    // Forward in CAPTURE and VALID with identical sources
    op_ready = 1'b0;
    request(4'd2, 4'd2);
    tick();
    wr(4'd2, 18'h00AAA);
    chk("fwd_cap_valid", {31'd0, op_valid}, 32'd1);
    chk("fwd_cap_op_a", {14'd0, op_a}, 32'h00AAA);
    chk("fwd_cap_op_b", {14'd0, op_b}, 32'h00AAA);
    wr(4'd9, 18'h00999);
    chk("unrelated_op_a", {14'd0, op_a}, 32'h00AAA);
    chk("unrelated_op_b", {14'd0, op_b}, 32'h00AAA);
    tick();
    chk("hold_valid", {31'd0, op_valid}, 32'd1);
    wr(4'd2, 18'h00BBB);
    chk("fwd_valid_op_a", {14'd0, op_a}, 32'h00BBB);
    chk("fwd_valid_op_b", {14'd0, op_b}, 32'h00BBB);

    // Backpressure with a competing request
    req_valid = 1'b1; req_src1 = 4'd3; req_src2 = 4'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_op_valid", {31'd0, op_valid}, 32'd1);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_addr1", {28'd0, rf_read_addr1}, 32'd2);
    end
    req_valid = 1'b0;
    chk("bp_op_a_held", {14'd0, op_a}, 32'h00BBB);
    op_ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, op_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, req_ready}, 32'd1);

    // Reset mid-operation in CAPTURE
    request(4'd3, 4'd7);
    tick();
    wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 18'h00001;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_mid_op_a", {14'd0, op_a}, 32'd0);
    chk("rst_mid_op_b", {14'd0, op_b}, 32'd0);
    chk("rst_mid_addr1", {28'd0, rf_read_addr1}, 32'd0);
    chk("rst_mid_addr2", {28'd0, rf_read_addr2}, 32'd0);
    chk("rst_mid_we", {31'd0, rf_write_enable}, 32'd0);
    wb_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    request(4'd3, 4'd7);
    tick();
    tick();
    chk("post_rst_valid", {31'd0, op_valid}, 32'd1);
    chk("post_rst_op_a", {14'd0, op_a}, 32'h00011);
    chk("post_rst_op_b", {14'd0, op_b}, 32'h3FFFF);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
